// File: rtl/wb_arbiter_n.sv
// N-master, single-slave Wishbone classic arbiter with fixed or round-robin priority.
// Grant is held for a master's whole cycle; a watchdog aborts transfers the slave never acks.
module wb_arbiter_n #(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RR_MODE        = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_MASTERS-1:0]                m_wb_cyc_i,
    input  logic [N_MASTERS-1:0]                m_wb_stb_i,
    input  logic [N_MASTERS-1:0]                m_wb_we_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]     m_wb_adr_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]     m_wb_dat_i,
    input  logic [N_MASTERS*(DATA_WIDTH/8)-1:0] m_wb_sel_i,
    output logic [N_MASTERS-1:0]                m_wb_ack_o,
    output logic [N_MASTERS-1:0]                m_wb_err_o,
    output logic [DATA_WIDTH-1:0]               m_wb_dat_o,
    output logic                                s_wb_cyc_o,
    output logic                                s_wb_stb_o,
    output logic                                s_wb_we_o,
    output logic [ADDR_WIDTH-1:0]               s_wb_adr_o,
    output logic [DATA_WIDTH-1:0]               s_wb_dat_o,
    output logic [DATA_WIDTH/8-1:0]             s_wb_sel_o,
    input  logic                                s_wb_ack_i,
    input  logic [DATA_WIDTH-1:0]               s_wb_dat_i,
    output logic [N_MASTERS-1:0]                grant_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W     = $clog2(N_MASTERS);
    // The counter never passes TIMEOUT_CYCLES-1, so clog2(TIMEOUT_CYCLES) bits suffice.
    localparam int WD_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT =
        WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

    state_t                 state, state_next;
    logic [N_MASTERS-1:0]   grant, grant_next;
    logic [IDX_W-1:0]       last_idx, last_idx_next;
    logic [IDX_W-1:0]       win_idx, cand;
    logic                   win_found;
    logic [WD_W-1:0]        wdog, wdog_next;

    logic                   sel_cyc, sel_stb, sel_we;
    logic [ADDR_WIDTH-1:0]  sel_adr;
    logic [DATA_WIDTH-1:0]  sel_dat;
    logic [SEL_WIDTH-1:0]   sel_byte;
    logic                   in_grant, timeout_hit;

    // Grant is one-hot, so an AND-OR mux selects the granted master's signals.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        sel_cyc  = 1'b0;
        sel_stb  = 1'b0;
        sel_we   = 1'b0;
        sel_adr  = '0;
        sel_dat  = '0;
        sel_byte = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (grant[k]) begin
                sel_cyc  = sel_cyc | m_wb_cyc_i[k];
                sel_stb  = sel_stb | m_wb_stb_i[k];
                sel_we   = sel_we  | m_wb_we_i[k];
                sel_adr  = sel_adr  | m_wb_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_dat  = sel_dat  | m_wb_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                sel_byte = sel_byte | m_wb_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
            end
        end
    end

    // Round-robin search starts just after the last winner; fixed mode starts at 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (RR_MODE != 0) cand = IDX_W'((int'(last_idx) + 1 + i) % N_MASTERS);
            else              cand = IDX_W'(i);
            if (!win_found && m_wb_cyc_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign in_grant    = (state == GRANT);
    assign s_wb_cyc_o  = in_grant & sel_cyc;
    assign s_wb_stb_o  = in_grant & sel_cyc & sel_stb;
    assign s_wb_we_o   = in_grant & sel_we;
    assign s_wb_adr_o  = in_grant ? sel_adr  : '0;
    assign s_wb_dat_o  = in_grant ? sel_dat  : '0;
    assign s_wb_sel_o  = in_grant ? sel_byte : '0;

    // An ack in the threshold cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && s_wb_stb_o && !s_wb_ack_i && (wdog == WD_LIMIT);

    assign m_wb_ack_o  = (in_grant && s_wb_ack_i) ? grant : '0;
    assign m_wb_err_o  = timeout_hit ? grant : '0;
    assign m_wb_dat_o  = s_wb_dat_i;
    assign grant_o     = grant;

    always_comb begin
        state_next    = state;
        grant_next    = grant;
        last_idx_next = last_idx;
        wdog_next     = wdog;
        case (state)
            IDLE: begin
                wdog_next = '0;
                if (win_found) begin
                    state_next          = GRANT;
                    grant_next          = '0;
                    grant_next[win_idx] = 1'b1;
                    last_idx_next       = win_idx;
                end
            end
            GRANT: begin
                if (s_wb_ack_i)                              wdog_next = '0;
                else if (s_wb_stb_o && TIMEOUT_CYCLES != 0)  wdog_next = wdog + 1'b1;
                if (!sel_cyc) begin
                    state_next = IDLE;
                    grant_next = '0;
                end else if (timeout_hit) begin
                    state_next = ABORT;
                end
            end
            ABORT: begin
                wdog_next = '0;
                if (!sel_cyc) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            last_idx <= IDX_W'(N_MASTERS - 1);
            wdog     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state    <= state_next;
            grant    <= grant_next;
            last_idx <= last_idx_next;
            wdog     <= wdog_next;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Self-checking bench for wb_arbiter_n: three instances cover round-robin with a short
// watchdog, fixed priority with the watchdog disabled, and four-master round-robin.
module tb_wb_arbiter_n;

    logic clk, reset;
    int   checks, errors;
    int   exp_grant_q[$];
    logic [31:0] exp_data_q[$];
    logic [1:0]  exp_err_q[$];

    // Instance A: N=2, RR, TIMEOUT_CYCLES=4
    logic [1:0]  a_cyc, a_stb, a_we, a_ack, a_err, a_grant;
    logic [63:0] a_adr, a_dat;
    logic [7:0]  a_sel;
    logic [31:0] a_mdat, a_sadr, a_sdat, a_sdat_i;
    logic [3:0]  a_ssel;
    logic        a_scyc, a_sstb, a_swe, a_sack;

    // Instance B: N=2, fixed priority, watchdog disabled
    logic [1:0]  b_cyc, b_stb, b_we, b_ack, b_err, b_grant;
    logic [63:0] b_adr, b_dat;
    logic [7:0]  b_sel;
    logic [31:0] b_mdat, b_sadr, b_sdat, b_sdat_i;
    logic [3:0]  b_ssel;
    logic        b_scyc, b_sstb, b_swe, b_sack;

    // Instance C: N=4, RR, zero-wait slave
    logic [3:0]   c_cyc, c_stb, c_we, c_ack, c_err, c_grant;
    logic [127:0] c_adr, c_dat;
    logic [15:0]  c_sel;
    logic [31:0]  c_mdat, c_sadr, c_sdat, c_sdat_i;
    logic [3:0]   c_ssel;
    logic         c_scyc, c_sstb, c_swe, c_sack;

    assign c_sack = c_sstb;

    wb_arbiter_n #(.N_MASTERS(2), .RR_MODE(1), .TIMEOUT_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset),
        .m_wb_cyc_i(a_cyc), .m_wb_stb_i(a_stb), .m_wb_we_i(a_we),
        .m_wb_adr_i(a_adr), .m_wb_dat_i(a_dat), .m_wb_sel_i(a_sel),
        .m_wb_ack_o(a_ack), .m_wb_err_o(a_err), .m_wb_dat_o(a_mdat),
        .s_wb_cyc_o(a_scyc), .s_wb_stb_o(a_sstb), .s_wb_we_o(a_swe),
        .s_wb_adr_o(a_sadr), .s_wb_dat_o(a_sdat), .s_wb_sel_o(a_ssel),
        .s_wb_ack_i(a_sack), .s_wb_dat_i(a_sdat_i), .grant_o(a_grant)
    );

    wb_arbiter_n #(.N_MASTERS(2), .RR_MODE(0), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset),
        .m_wb_cyc_i(b_cyc), .m_wb_stb_i(b_stb), .m_wb_we_i(b_we),
        .m_wb_adr_i(b_adr), .m_wb_dat_i(b_dat), .m_wb_sel_i(b_sel),
        .m_wb_ack_o(b_ack), .m_wb_err_o(b_err), .m_wb_dat_o(b_mdat),
        .s_wb_cyc_o(b_scyc), .s_wb_stb_o(b_sstb), .s_wb_we_o(b_swe),
        .s_wb_adr_o(b_sadr), .s_wb_dat_o(b_sdat), .s_wb_sel_o(b_ssel),
        .s_wb_ack_i(b_sack), .s_wb_dat_i(b_sdat_i), .grant_o(b_grant)
    );

    wb_arbiter_n #(.N_MASTERS(4), .RR_MODE(1), .TIMEOUT_CYCLES(255)) dut_c (
        .clk(clk), .reset(reset),
        .m_wb_cyc_i(c_cyc), .m_wb_stb_i(c_stb), .m_wb_we_i(c_we),
        .m_wb_adr_i(c_adr), .m_wb_dat_i(c_dat), .m_wb_sel_i(c_sel),
        .m_wb_ack_o(c_ack), .m_wb_err_o(c_err), .m_wb_dat_o(c_mdat),
        .s_wb_cyc_o(c_scyc), .s_wb_stb_o(c_sstb), .s_wb_we_o(c_swe),
        .s_wb_adr_o(c_sadr), .s_wb_dat_o(c_sdat), .s_wb_sel_o(c_ssel),
        .s_wb_ack_i(c_sack), .s_wb_dat_i(c_sdat_i), .grant_o(c_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Return 1 ns after the rising edge so registered outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_cyc = '0; a_stb = '0; a_we = '0; a_adr = '0; a_dat = '0; a_sel = '0; a_sack = 1'b0; a_sdat_i = '0;
        b_cyc = '0; b_stb = '0; b_we = '0; b_adr = '0; b_dat = '0; b_sel = '0; b_sack = 1'b0; b_sdat_i = '0;
        c_cyc = '0; c_stb = '0; c_we = '0; c_adr = '0; c_dat = '0; c_sel = '0; c_sdat_i = '0;
        a_adr[31:0] = 32'h8000_0010;
        a_cyc = 2'b11; a_stb = 2'b11;
        repeat (3) tick();
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", a_grant); end
        checks++; if ({a_scyc, a_sstb, a_swe} !== 3'b000) begin errors++; $display("FAIL reset_slave_ctl got %b exp 000", {a_scyc, a_sstb, a_swe}); end
        checks++; if (a_sadr !== 32'h0) begin errors++; $display("FAIL reset_adr got %h exp 0", a_sadr); end
        checks++; if ({a_ack, a_err} !== 4'b0) begin errors++; $display("FAIL reset_ack_err got %b exp 0000", {a_ack, a_err}); end
        a_cyc = '0; a_stb = '0;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_rr_basic();
        a_adr[31:0]  = 32'h8000_0010;
        a_adr[63:32] = 32'h0000_1000;
        a_cyc = 2'b11; a_stb = 2'b11; a_we = 2'b00;
        exp_grant_q.push_back(0); exp_grant_q.push_back(1); exp_grant_q.push_back(0);
        tick();
        checks++; if (a_grant !== 2'(1 << exp_grant_q.pop_front())) begin errors++; $display("FAIL rr_first_grant got %b exp 01", a_grant); end
        checks++; if ({a_scyc, a_sstb} !== 2'b11) begin errors++; $display("FAIL rr_slave_cyc_stb got %b exp 11", {a_scyc, a_sstb}); end
        checks++; if (a_sadr !== 32'h8000_0010) begin errors++; $display("FAIL rr_read_adr got %h exp 80000010", a_sadr); end
        a_sack = 1'b1; a_sdat_i = 32'hDEAD_BEEF;
        exp_data_q.push_back(32'hDEAD_BEEF);
        #1;
        checks++; if (a_ack !== 2'b01) begin errors++; $display("FAIL read_ack got %b exp 01", a_ack); end
        checks++; if (a_mdat !== exp_data_q.pop_front()) begin errors++; $display("FAIL read_data got %h exp deadbeef", a_mdat); end
        tick();
        a_cyc[0] = 1'b0; a_stb[0] = 1'b0; a_sack = 1'b0;
        #1;
        checks++; if (a_scyc !== 1'b0) begin errors++; $display("FAIL rr_cyc_drop_comb got %b exp 0", a_scyc); end
        tick();
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL rr_idle_gap got %b exp 00", a_grant); end
        a_cyc[0] = 1'b1; a_stb[0] = 1'b1;
        tick();
        checks++; if (a_grant !== 2'(1 << exp_grant_q.pop_front())) begin errors++; $display("FAIL rr_second_grant got %b exp 10", a_grant); end
        checks++; if (a_sadr !== 32'h0000_1000) begin errors++; $display("FAIL rr_m1_adr got %h exp 00001000", a_sadr); end
        a_sack = 1'b1;
        #1;
        checks++; if (a_ack !== 2'b10) begin errors++; $display("FAIL rr_m1_ack got %b exp 10", a_ack); end
        tick();
        a_cyc[1] = 1'b0; a_stb[1] = 1'b0; a_sack = 1'b0;
        tick();
        checks++; if (a_sstb !== 1'b0) begin errors++; $display("FAIL waiting_stb_forwarded got %b exp 0", a_sstb); end
        tick();
        checks++; if (a_grant !== 2'(1 << exp_grant_q.pop_front())) begin errors++; $display("FAIL rr_m0_after_wait got %b exp 01", a_grant); end
        a_cyc = '0; a_stb = '0;
        tick(); tick();
    endtask

    task automatic test_timeout();
        a_cyc = 2'b01; a_stb = 2'b01; a_sack = 1'b0;
        exp_err_q.push_back(2'b00); exp_err_q.push_back(2'b00);
        exp_err_q.push_back(2'b00); exp_err_q.push_back(2'b01);
        for (int c = 1; c <= 4; c++) begin
            logic [1:0] e;
            tick();
            e = exp_err_q.pop_front();
            checks++; if (a_err !== e) begin errors++; $display("FAIL timeout_err_cycle%0d got %b exp %b", c, a_err, e); end
        end
        tick();
        checks++; if ({a_scyc, a_sstb} !== 2'b00) begin errors++; $display("FAIL abort_slave_off got %b exp 00", {a_scyc, a_sstb}); end
        checks++; if ({a_grant, a_err} !== 4'b0100) begin errors++; $display("FAIL abort_grant_err got %b exp 0100", {a_grant, a_err}); end
        a_sack = 1'b1;
        #1;
        checks++; if (a_ack !== 2'b00) begin errors++; $display("FAIL abort_late_ack got %b exp 00", a_ack); end
        tick();
        a_cyc = '0; a_stb = '0; a_sack = 1'b0;
        tick();
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL abort_release got %b exp 00", a_grant); end
        tick();
    endtask

    task automatic test_timeout_disabled();
        int bad;
        bad = 0;
        b_cyc = 2'b01; b_stb = 2'b01; b_sack = 1'b0;
        tick();
        for (int c = 0; c < 300; c++) begin
            if (b_scyc !== 1'b1 || b_err !== 2'b00 || b_grant !== 2'b01) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL no_watchdog_hold bad_cycles %0d exp 0", bad); end
        b_cyc = '0; b_stb = '0;
        tick(); tick();
    endtask

    task automatic test_fixed_priority();
        b_cyc = 2'b10; b_stb = 2'b10;
        tick();
        checks++; if (b_grant !== 2'b10) begin errors++; $display("FAIL fixed_m1_grant got %b exp 10", b_grant); end
        b_cyc[0] = 1'b1; b_stb[0] = 1'b1; b_sack = 1'b1;
        for (int beat = 0; beat < 4; beat++) begin
            #1;
            checks++; if ({b_grant, b_ack} !== 4'b1010) begin errors++; $display("FAIL fixed_burst_beat%0d got %b exp 1010", beat, {b_grant, b_ack}); end
            tick();
        end
        b_sack = 1'b0;
        b_cyc[1] = 1'b0; b_stb[1] = 1'b0;
        tick();
        checks++; if (b_grant !== 2'b00) begin errors++; $display("FAIL fixed_idle_gap got %b exp 00", b_grant); end
        tick();
        checks++; if (b_grant !== 2'b01) begin errors++; $display("FAIL fixed_m0_after_burst got %b exp 01", b_grant); end
        b_cyc[0] = 1'b0; b_stb[0] = 1'b0;
        tick();
        for (int r = 0; r < 2; r++) begin
            b_cyc = 2'b11; b_stb = 2'b11;
            tick();
            checks++; if (b_grant !== 2'b01) begin errors++; $display("FAIL fixed_both_round%0d got %b exp 01", r, b_grant); end
            b_cyc[0] = 1'b0; b_stb[0] = 1'b0;
            tick();
        end
        b_cyc = '0; b_stb = '0;
        tick(); tick();
    endtask

    task automatic test_rr4_order();
        logic [3:0] drop_now, reraise, prev_g;
        int seen, e;
        for (int k = 0; k < 4; k++) exp_grant_q.push_back(k);
        exp_grant_q.push_back(0);
        drop_now = '0; reraise = '0; prev_g = '0; seen = 0;
        c_cyc = 4'hF; c_stb = 4'hF;
        for (int n = 0; n < 60 && seen < 5; n++) begin
            tick();
            c_cyc = c_cyc | reraise;  c_stb = c_stb | reraise;
            reraise = drop_now;
            c_cyc = c_cyc & ~drop_now; c_stb = c_stb & ~drop_now;
            drop_now = '0;
            if (c_grant !== 4'b0 && c_grant !== prev_g) begin
                e = exp_grant_q.pop_front();
                checks++; if (c_grant !== 4'(1 << e)) begin errors++; $display("FAIL rr4_grant%0d got %b exp %b", seen, c_grant, 4'(1 << e)); end
                seen++;
            end
            prev_g = c_grant;
            #1;
            drop_now = c_ack;
        end
        if (seen < 5) begin
            checks++; errors++;
            $display("FAIL rr4_timeout grants_seen %0d exp 5", seen);
        end
        c_cyc = '0; c_stb = '0;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        a_cyc = 2'b01; a_stb = 2'b01;
        tick();
        checks++; if (a_grant !== 2'b01) begin errors++; $display("FAIL pre_reset_grant got %b exp 01", a_grant); end
        a_sack = 1'b1; a_sdat_i = '0;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL midreset_grant got %b exp 00", a_grant); end
        checks++; if ({a_scyc, a_sstb, a_ack, a_err} !== 6'b0) begin errors++; $display("FAIL midreset_outputs got %b exp 000000", {a_scyc, a_sstb, a_ack, a_err}); end
        a_sack = 1'b0;
        a_cyc = 2'b11; a_stb = 2'b11;
        @(posedge clk);
        #2;
        reset = 1'b0;
        tick();
        checks++; if (a_grant !== 2'b01) begin errors++; $display("FAIL post_reset_first_grant got %b exp 01", a_grant); end
        a_cyc = '0; a_stb = '0;
        tick(); tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rr_basic();
        test_timeout();
        test_timeout_disabled();
        test_fixed_priority();
        test_rr4_order();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_n.md
Name: wb_arbiter_n

Overview:
- N-master, single-slave Wishbone classic arbiter, parametrised in master count and arbitration mode.
- Merges the CPU's independent fetch and data-memory Wishbone masters (plus future DMA/debug masters) onto one shared bus port.
- Grant is held for a master's whole cycle (cyc high), so single and burst transfers are never interleaved.
- A bus-timeout watchdog aborts hung transfers with an error pulse.

Parameters:
- N_MASTERS, 2, number of master ports (2..8).
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; select width is DATA_WIDTH/8.
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT_CYCLES, 255, cycles of stb without ack before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- m_wb_cyc_i  in  N_MASTERS  per-master cyc
- m_wb_stb_i  in  N_MASTERS  per-master stb
- m_wb_we_i  in  N_MASTERS  per-master write enable
- m_wb_adr_i  in  N_MASTERS*ADDR_WIDTH  packed addresses; master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- m_wb_dat_i  in  N_MASTERS*DATA_WIDTH  packed write data
- m_wb_sel_i  in  N_MASTERS*DATA_WIDTH/8  packed byte selects
- m_wb_ack_o  out  N_MASTERS  per-master ack
- m_wb_err_o  out  N_MASTERS  per-master timeout error
- m_wb_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  1  slave control
- s_wb_adr_o  out  ADDR_WIDTH  slave address
- s_wb_dat_o  out  DATA_WIDTH  slave write data
- s_wb_sel_o  out  DATA_WIDTH/8  slave byte select
- s_wb_ack_i  in  1  slave ack
- s_wb_dat_i  in  DATA_WIDTH  slave read data
- grant_o  out  N_MASTERS  registered one-hot grant (all zero when idle)

Behaviour:
- Registered state machine: IDLE, GRANT, ABORT; registered one-hot grant; registered round-robin pointer last_idx.
- Reset, applied asynchronously at any time including mid-transfer:
  - state=IDLE, grant=0, last_idx=N_MASTERS-1 (master 0 wins first in RR mode), watchdog=0.
  - All outputs 0; no ack or err is emitted for an interrupted transfer.
- IDLE:
  - If any m_wb_cyc_i is high, choose a winner and go to GRANT with the winner's grant bit set; otherwise stay in IDLE.
  - Fixed mode: winner is the lowest requesting index.
  - RR mode: winner is the first requesting index searching last_idx+1, last_idx+2, ... modulo N_MASTERS. last_idx updates to the winner on grant.
  - Arbitration latency: 1 cycle from the cyc rise to s_wb_cyc_o.
- GRANT:
  - s_wb_cyc/stb/we/adr/dat/sel are a combinational mux of the granted master's inputs.
  - m_wb_ack_o[g] = s_wb_ack_i & grant[g]; the other masters' acks are always 0.
  - m_wb_dat_o = s_wb_dat_i at all times.
  - When the granted master drops cyc: go to IDLE, and slave outputs drop in the same cycle (combinational).
  - Requests raised during GRANT wait. A waiting master sees a minimum of 1 idle cycle, then is granted on the following edge.
- Watchdog:
  - Counts cycles in GRANT with s_wb_stb_o=1 and s_wb_ack_i=0.
  - Clears on any ack and on entering GRANT.
  - When count == TIMEOUT_CYCLES-1 with no ack that cycle: next state ABORT, and m_wb_err_o[g] pulses high for exactly that one cycle.
  - TIMEOUT_CYCLES=0: watchdog is never armed.
- ABORT:
  - All slave outputs forced 0 and grant held.
  - Stay until the granted master drops cyc, then go to IDLE.
  - A late s_wb_ack_i in ABORT is ignored (no m_wb_ack_o).
- A master dropping cyc while its stb is pending is a legal abandon: the transfer is released without ack.
- Simultaneous ack and timeout threshold: ack wins, no err.
- Non-granted masters' stb is never forwarded, even when it is held high.

Test Plan:
- N=2, RR_MODE=1: both masters raise cyc/stb at cycle 0 -> grant_o=01 at cycle 1 and master 0 acked. After master 0 drops cyc, grant_o=10 two cycles later; master 0 re-requesting then waits behind master 1.
- N=2, RR_MODE=0: master 1 holds cyc continuously and master 0 requests during master 1's burst of 4 acks -> master 0 granted only after master 1 drops cyc. When both request from IDLE, master 0 always wins.
- N=4, RR_MODE=1: all four request continuously with single-beat cycles -> grant order 0,1,2,3,0.
- Master 0 read of 0x8000_0010 with slave returning 0xDEADBEEF on ack -> m_wb_dat_o=0xDEADBEEF and m_wb_ack_o=01; master 1 ack stays 0.
- TIMEOUT_CYCLES=4, slave never acks -> m_wb_err_o[0] pulses 1 cycle after 4 stb cycles; s_wb_cyc_o=0 from the next cycle; a later slave ack is ignored; IDLE once master drops cyc. With TIMEOUT_CYCLES=0 the bus stays granted indefinitely.
- reset asserted mid-transfer (asynchronously, between edges) -> all outputs 0 immediately. After release, master 0 is first grant in RR mode.
